// File: rtl/countdown_timer8_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings and the
// active-low seven-segment glyph table (bit 0 = segment a ... bit 6 = g).
package countdown_timer8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/countdown_timer8_hex_seg_decoder.sv
// One hex digit to active-low seven-segment pattern; every nibble value
// shows a glyph, nothing is blanked.
module hex_seg_decoder
  import countdown_timer8_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Pure table lookup so the display tracks the nibble with no latency.
  always_comb begin
    seg_n = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/countdown_timer8.sv
// Loadable 8-bit countdown timer: rate divider, start/pause/resume control,
// optional auto-reload, one-cycle terminal-count pulse and two hex displays.
module countdown_timer8
  import countdown_timer8_pkg::*;
#(
  parameter int DIV_MAX = 49_999_999
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] load_val,
  input  logic       load,
  input  logic       go,
  input  logic       auto_reload,
  output logic [7:0] count,
  output logic [1:0] state,
  output logic       done,
  output logic       tc_pulse,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic             load_prev_q, load_prev_d;
  logic             go_prev_q, go_prev_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       reload_q, reload_d;
  logic [DIV_W-1:0] div_q, div_d;
  state_e           state_q, state_d;
  logic             tc_q, tc_d;
  logic             load_evt, go_evt;

  assign load_evt = load & ~load_prev_q;
  assign go_evt   = go & ~go_prev_q;

  // State register: all timer state clears immediately on clear, which also
  // kills any tc pulse that was about to be produced.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      load_prev_q <= 1'b0;
      go_prev_q   <= 1'b0;
      count_q     <= 8'd0;
      reload_q    <= 8'd0;
      div_q       <= '0;
      state_q     <= ST_IDLE;
      tc_q        <= 1'b0;
    end else begin
      load_prev_q <= load_prev_d;
      go_prev_q   <= go_prev_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      div_q       <= div_d;
      state_q     <= state_d;
      tc_q        <= tc_d;
    end
  end

  // Next-state and datapath: load wins over everything, go pauses before a
  // pending tick can fire, and expiry either reloads or parks in DONE.
  always_comb begin
    load_prev_d = load;
    go_prev_d   = go;
    count_d     = count_q;
    reload_d    = reload_q;
    div_d       = div_q;
    state_d     = state_q;
    tc_d        = 1'b0;

    if (load_evt) begin
      count_d  = load_val;
      reload_d = load_val;
      div_d    = '0;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go_evt && (count_q != 8'd0)) begin
            div_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (go_evt) begin
            state_d = ST_PAUSE;
          end else if (div_q == DIV_TERM) begin
            div_d = '0;
            if (count_q == 8'd1) begin
              tc_d = 1'b1;
              if (auto_reload && (reload_q != 8'd0)) begin
                count_d = reload_q;
              end else begin
                count_d = 8'd0;
                state_d = ST_DONE;
              end
            end else if (count_q != 8'd0) begin
              count_d = count_q - 8'd1;
            end
          end else begin
            div_d = div_q + DIV_ONE;
          end
        end
        ST_PAUSE: begin
          if (go_evt) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (go_evt && (reload_q != 8'd0)) begin
            count_d = reload_q;
            div_d   = '0;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs come straight from registers, so done tracks state with no lag.
  always_comb begin
    count    = count_q;
    state    = state_q;
    done     = (state_q == ST_DONE);
    tc_pulse = tc_q;
  end

  hex_seg_decoder u_hex0 (
    .nibble (count_q[3:0]),
    .seg_n  (hex0)
  );

  hex_seg_decoder u_hex1 (
    .nibble (count_q[7:4]),
    .seg_n  (hex1)
  );

endmodule
